// File: rtl/mem_access_unit.sv
// Data-memory access unit for the MEM stage: turns load/store requests into a
// single registered bus transaction and formats the returned load data.
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] i_mem_alu_result,
    input  logic [31:0] i_mem_store_data,
    input  logic [2:0]  i_mem_funct3,
    input  logic        i_mem_mem_read,
    input  logic        i_mem_mem_write,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [31:0] o_dbus_addr,
    output logic [31:0] o_dbus_wdata,
    output logic [3:0]  o_dbus_be,
    input  logic        i_dbus_ack,
    input  logic [31:0] i_dbus_rdata,
    output logic [31:0] o_mem_load_data,
    output logic        o_mem_stall,
    output logic        o_mem_fault
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [2:0]  r_funct3;
    logic [31:0] r_load_data;

    logic        w_idle;
    logic        w_access;
    logic        w_both;
    logic        w_f3_ok;
    logic        w_aligned;
    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_fmt;

    assign w_idle   = (r_state == S_IDLE);
    assign w_access = i_mem_mem_read ^ i_mem_mem_write;
    assign w_both   = i_mem_mem_read & i_mem_mem_write;
    assign w_legal  = w_access & w_f3_ok & w_aligned;

    // Request decode: legality, lane enables and replicated store data.
    always_comb begin
        w_f3_ok = 1'b0;
        if (i_mem_mem_read) begin
            case (i_mem_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end else if (i_mem_mem_write) begin
            case (i_mem_funct3)
                3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
                default:                w_f3_ok = 1'b0;
            endcase
        end

        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = i_mem_store_data;
        case (i_mem_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_mem_alu_result[1:0];
                w_wdata = {4{i_mem_store_data[7:0]}};
            end
            2'b01: begin
                w_aligned = ~i_mem_alu_result[0];
                w_be      = i_mem_alu_result[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{i_mem_store_data[15:0]}};
            end
            default: begin
                w_aligned = (i_mem_alu_result[1:0] == 2'b00);
            end
        endcase
        if (!i_mem_mem_write) begin
            w_wdata = 32'd0;
        end
    end

    // Load formatting uses the captured address/size so a changing pipeline
    // input during the wait cannot corrupt the result.
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = i_dbus_rdata[7:0];
            2'b01:   w_byte = i_dbus_rdata[15:8];
            2'b10:   w_byte = i_dbus_rdata[23:16];
            default: w_byte = i_dbus_rdata[31:24];
        endcase
        w_half = r_addr[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_fmt = {24'd0, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = i_dbus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_funct3    <= 3'd0;
            r_load_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_legal) begin
                        r_state  <= S_BUSY;
                        r_we     <= i_mem_mem_write;
                        r_addr   <= i_mem_alu_result;
                        r_wdata  <= w_wdata;
                        r_be     <= w_be;
                        r_funct3 <= i_mem_funct3;
                    end
                end
                S_BUSY: begin
                    if (i_dbus_ack) begin
                        r_state <= S_DONE;
                        if (!r_we) begin
                            r_load_data <= w_load_fmt;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_dbus_req      = (r_state == S_BUSY);
    assign o_dbus_we       = r_we;
    assign o_dbus_addr     = r_addr;
    assign o_dbus_wdata    = r_wdata;
    assign o_dbus_be       = r_be;
    assign o_mem_load_data = r_load_data;
    assign o_mem_stall     = (w_idle & w_legal) | (r_state == S_BUSY);
    assign o_mem_fault     = w_idle & ((w_access & ~w_legal) | w_both);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// accesses compared against a behavioural model of the access rules.
module tb_mem_access_unit;

    logic        clk;
    logic        resetn;
    logic [31:0] i_mem_alu_result;
    logic [31:0] i_mem_store_data;
    logic [2:0]  i_mem_funct3;
    logic        i_mem_mem_read;
    logic        i_mem_mem_write;
    logic        o_dbus_req;
    logic        o_dbus_we;
    logic [31:0] o_dbus_addr;
    logic [31:0] o_dbus_wdata;
    logic [3:0]  o_dbus_be;
    logic        i_dbus_ack;
    logic [31:0] i_dbus_rdata;
    logic [31:0] o_mem_load_data;
    logic        o_mem_stall;
    logic        o_mem_fault;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_load = 32'd0;

    mem_access_unit dut (
        .clk              (clk),
        .resetn           (resetn),
        .i_mem_alu_result (i_mem_alu_result),
        .i_mem_store_data (i_mem_store_data),
        .i_mem_funct3     (i_mem_funct3),
        .i_mem_mem_read   (i_mem_mem_read),
        .i_mem_mem_write  (i_mem_mem_write),
        .o_dbus_req       (o_dbus_req),
        .o_dbus_we        (o_dbus_we),
        .o_dbus_addr      (o_dbus_addr),
        .o_dbus_wdata     (o_dbus_wdata),
        .o_dbus_be        (o_dbus_be),
        .i_dbus_ack       (i_dbus_ack),
        .i_dbus_rdata     (i_dbus_rdata),
        .o_mem_load_data  (o_mem_load_data),
        .o_mem_stall      (o_mem_stall),
        .o_mem_fault      (o_mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] addr);
        int size;
        bit f3_ok;
        if (rd == wr) return 1'b0;
        f3_ok = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        size  = 1 << (f3 % 4);
        return f3_ok && ((addr % size) == 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int bsz;
        bsz = 1 << (f3 % 4);
        if (bsz == 4) return 4'hF;
        return 4'((bsz == 1 ? 1 : 3) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input bit wr, input logic [2:0] f3,
                                                input logic [31:0] d);
        if (!wr) return 32'd0;
        if (f3 % 4 == 0) return (d & 32'hFF) * 32'h01010101;
        if (f3 % 4 == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] b;
        logic [31:0] h;
        b = (rdata >> ((addr % 4) * 8)) & 32'hFF;
        h = (rdata >> ((addr % 4) / 2 * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b + 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h + 32'hFFFF0000) : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    // One instruction presented to the MEM stage, held while stalled, with
    // the bus acking after 'waits' wait cycles.
    task automatic run_access(input string name, input bit rd, input bit wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input int waits,
                              input logic [31:0] rdata);
        bit          go;
        bit          exp_fault;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          busy_cycles;
        go        = model_legal(rd, wr, f3, addr);
        exp_fault = (rd && wr) || ((rd != wr) && !go);
        e_be      = model_be(f3, addr);
        e_wdata   = model_wdata(wr, f3, sdata);
        busy_cycles = 0;

        @(posedge clk); #1;
        i_mem_mem_read   = rd;
        i_mem_mem_write  = wr;
        i_mem_funct3     = f3;
        i_mem_alu_result = addr;
        i_mem_store_data = sdata;
        i_dbus_ack       = 1'($urandom_range(0, 1));
        i_dbus_rdata     = $urandom;
        #1;
        n_checks++;
        if (o_mem_fault !== exp_fault) begin
            n_fail++;
            $display("FAIL %s fault: got %b expected %b", name, o_mem_fault, exp_fault);
        end
        n_checks++;
        if (o_mem_stall !== go) begin
            n_fail++;
            $display("FAIL %s idle_stall: got %b expected %b", name, o_mem_stall, go);
        end
        n_checks++;
        if (o_dbus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_req: got %b expected 0", name, o_dbus_req);
        end

        if (!go) begin
            @(posedge clk); #1;
            i_mem_mem_read  = 1'b0;
            i_mem_mem_write = 1'b0;
            n_checks++;
            if (o_dbus_req !== 1'b0) begin
                n_fail++;
                $display("FAIL %s no_req: got %b expected 0", name, o_dbus_req);
            end
            n_checks++;
            if (o_mem_load_data !== exp_load) begin
                n_fail++;
                $display("FAIL %s load_hold: got %h expected %h", name, o_mem_load_data, exp_load);
            end
            $display("txn %s rd=%0d wr=%0d f3=%0d addr=%h fault=%0d", name, rd, wr, f3, addr, exp_fault);
            return;
        end

        for (int k = 0; k <= waits; k++) begin
            @(posedge clk); #1;
            i_dbus_ack   = (k == waits);
            i_dbus_rdata = (k == waits) ? rdata : $urandom;
            if (k > 0) begin
                i_mem_alu_result = $urandom;
                i_mem_store_data = $urandom;
                i_mem_funct3     = 3'($urandom_range(0, 7));
            end
            #1;
            busy_cycles++;
            n_checks++;
            if ({o_dbus_req, o_mem_stall, o_mem_fault} !== 3'b110) begin
                n_fail++;
                $display("FAIL %s busy_ctl[%0d]: got req/stall/fault=%b expected 110", name, k,
                         {o_dbus_req, o_mem_stall, o_mem_fault});
            end
            n_checks++;
            if ({o_dbus_we, o_dbus_be, o_dbus_addr, o_dbus_wdata} !== {wr, e_be, addr, e_wdata}) begin
                n_fail++;
                $display("FAIL %s bus[%0d]: got we=%b be=%b addr=%h wdata=%h expected we=%b be=%b addr=%h wdata=%h",
                         name, k, o_dbus_we, o_dbus_be, o_dbus_addr, o_dbus_wdata, wr, e_be, addr, e_wdata);
            end
        end

        @(posedge clk); #1;
        if (rd) exp_load = model_load(f3, addr, rdata);
        i_mem_mem_read  = 1'b0;
        i_mem_mem_write = 1'b0;
        i_dbus_ack      = 1'($urandom_range(0, 1));
        i_dbus_rdata    = $urandom;
        #1;
        n_checks++;
        if ({o_dbus_req, o_mem_stall, o_mem_fault} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s done_ctl: got req/stall/fault=%b expected 000", name,
                     {o_dbus_req, o_mem_stall, o_mem_fault});
        end
        n_checks++;
        if (o_mem_load_data !== exp_load) begin
            n_fail++;
            $display("FAIL %s load_data: got %h expected %h", name, o_mem_load_data, exp_load);
        end
        $display("txn %s rd=%0d wr=%0d f3=%0d addr=%h be=%b busy=%0d load=%h", name, rd, wr, f3, addr,
                 e_be, busy_cycles, exp_load);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        i_mem_alu_result = 32'd0;
        i_mem_store_data = 32'd0;
        i_mem_funct3     = 3'd0;
        i_mem_mem_read   = 1'b0;
        i_mem_mem_write  = 1'b0;
        i_dbus_ack       = 1'b0;
        i_dbus_rdata     = 32'd0;
        #1;
        n_checks++;
        if ({o_dbus_req, o_dbus_we, o_dbus_be, o_dbus_addr, o_dbus_wdata, o_mem_load_data,
             o_mem_stall, o_mem_fault} !== 104'd0) begin
            n_fail++;
            $display("FAIL reset_state: got req=%b we=%b be=%b addr=%h wdata=%h load=%h stall=%b fault=%b expected all 0",
                     o_dbus_req, o_dbus_we, o_dbus_be, o_dbus_addr, o_dbus_wdata, o_mem_load_data,
                     o_mem_stall, o_mem_fault);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_lw();
        run_access("lw_0x100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    endtask

    task automatic test_sub_word_loads();
        run_access("lb_0x203", 1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80112233);
        run_access("lbu_0x203", 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 1, 32'h80112233);
        run_access("lhu_0x202", 1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 0, 32'h80112233);
        run_access("lh_0x202", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 2, 32'h80112233);
    endtask

    task automatic test_store_wait();
        run_access("sh_0x12", 1'b0, 1'b1, 3'b001, 32'h12, 32'h0000ABCD, 3, 32'h0);
        run_access("sb_0x11", 1'b0, 1'b1, 3'b000, 32'h11, 32'h123456A5, 0, 32'h0);
    endtask

    task automatic test_faults();
        run_access("lw_mis_0x101", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
        run_access("sh_mis_0x13", 1'b0, 1'b1, 3'b001, 32'h13, 32'h5555, 0, 32'h0);
        run_access("sbu_illegal", 1'b0, 1'b1, 3'b100, 32'h20, 32'h5555, 0, 32'h0);
        run_access("rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h40, 32'h5555, 0, 32'h0);
    endtask

    task automatic test_reset_busy();
        @(posedge clk); #1;
        i_mem_mem_read   = 1'b1;
        i_mem_funct3     = 3'b010;
        i_mem_alu_result = 32'h40;
        i_dbus_ack       = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (o_dbus_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_busy req_before: got %b expected 1", o_dbus_req);
        end
        #2;
        resetn         = 1'b0;
        i_mem_mem_read = 1'b0;
        exp_load       = 32'd0;
        #1;
        n_checks++;
        if ({o_dbus_req, o_dbus_we, o_dbus_be, o_dbus_addr, o_dbus_wdata, o_mem_load_data,
             o_mem_stall} !== 103'd0) begin
            n_fail++;
            $display("FAIL rst_busy outputs: got req=%b be=%b addr=%h load=%h stall=%b expected all 0",
                     o_dbus_req, o_dbus_be, o_dbus_addr, o_mem_load_data, o_mem_stall);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_dbus_ack   = 1'b1;
        i_dbus_rdata = 32'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            i_dbus_ack = 1'b0;
            n_checks++;
            if ({o_dbus_req, o_mem_load_data} !== 33'd0) begin
                n_fail++;
                $display("FAIL rst_busy late_ack[%0d]: got req=%b load=%h expected req=0 load=0",
                         k, o_dbus_req, o_mem_load_data);
            end
        end
        $display("txn reset during busy, late ack ignored");
    endtask

    task automatic test_back_to_back();
        run_access("b2b_lw", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h01234567);
        run_access("b2b_sw", 1'b0, 1'b1, 3'b010, 32'h304, 32'h89ABCDEF, 0, 32'h0);
        run_access("b2b_lw2", 1'b1, 1'b0, 3'b010, 32'h308, 32'h0, 0, 32'h76543210);
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            int          kind;
            bit          rd;
            bit          wr;
            kind = $urandom_range(0, 9);
            rd   = (kind <= 4) || (kind == 9);
            wr   = ((kind >= 5) && (kind <= 7)) || (kind == 9);
            run_access($sformatf("rnd%0d", i), rd, wr, 3'($urandom_range(0, 7)),
                       {$urandom_range(0, 32'hFFFF), 14'($urandom_range(0, 16383)), 2'($urandom_range(0, 3))},
                       $urandom, $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub_word_loads();
        test_store_wait();
        test_faults();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have ports: resetn  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have ports: i_mem_alu_result  in  32  effective byte address from EX/MEM.
REQ-004 SHALL have ports: i_mem_store_data  in  32  rs2 value for stores.
REQ-005 SHALL have ports: i_mem_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 SHALL have ports: i_mem_mem_read, i_mem_mem_write  in  1 each  load / store request of the current MEM instruction.
REQ-007 SHALL have ports: o_dbus_req  out  1  bus request; o_dbus_we  out  1  write; o_dbus_addr  out  32  byte address; o_dbus_wdata  out  32  lane-replicated store data; o_dbus_be  out  4  byte enables.
REQ-008 SHALL have ports: i_dbus_ack  in  1  bus completion; i_dbus_rdata  in  32  read word, valid with ack.
REQ-009 SHALL have ports: o_mem_load_data  out  32  formatted load result to MEM/WB; o_mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; o_mem_fault  out  1  misaligned/illegal access.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 "access" = exactly one of mem_read/mem_write high; "legal" = funct3 valid for the direction (loads: 000,001,010,100,101; stores: 000,001,010) and aligned (H: addr[0]=0; W: addr[1:0]=0).
REQ-012 o_mem_fault SHALL be combinational = IDLE and ((access and not legal) or both read and write high); faulting instruction issues no bus request and does not stall.
REQ-013 IDLE -> BUSY on rising edge when access and legal; otherwise remain IDLE.
REQ-014 On entering BUSY, o_dbus_addr, o_dbus_we, o_dbus_wdata, o_dbus_be SHALL be registered and held stable while o_dbus_req=1; o_dbus_req=1 exactly while in BUSY.
REQ-015 BUSY -> DONE on rising edge with i_dbus_ack=1; BUSY holds indefinitely while ack=0.
REQ-016 DONE -> IDLE unconditionally after one cycle.
REQ-017 o_mem_stall SHALL be combinational = (IDLE and access and legal) or BUSY; 0 in DONE so EX/MEM and MEM/WB advance on the DONE edge.
REQ-018 Minimum latency: access presented cycle 0, req cycle 1, ack cycle 1, DONE cycle 2, pipeline advances at end of cycle 2.
REQ-019 Store lanes: SB be=0001<<addr[1:0], wdata={4{data[7:0]}}; SH be=0011<<(2*addr[1]), wdata={2{data[15:0]}}; SW be=1111, wdata=data.
REQ-020 Loads SHALL drive be per REQ-019 with we=0, wdata=0.
REQ-021 On ack in BUSY for a load, o_mem_load_data SHALL register: LB/LBU byte at addr[1:0] sign/zero-extended; LH/LHU halfword at addr[1] sign/zero-extended; LW full word.
REQ-022 o_mem_load_data SHALL hold its value otherwise (stores, faults, idle cycles).
REQ-023 i_dbus_ack in IDLE or DONE SHALL be ignored; i_dbus_rdata ignored when ack=0.
REQ-024 Input changes while BUSY SHALL not affect registered bus outputs.

Reset
REQ-025 resetn low SHALL immediately force IDLE, o_dbus_req=0, o_dbus_we=0, o_dbus_addr=0, o_dbus_wdata=0, o_dbus_be=0, o_mem_load_data=0.
REQ-026 Reset during BUSY SHALL abandon the transaction; an ack arriving after reset release SHALL be ignored.

Verification
REQ-027 LW addr 0x100, ack first cycle, rdata 0xDEADBEEF -> req 1 cycle, be=1111, load_data=0xDEADBEEF in DONE, stall 2 cycles.
REQ-028 LB addr 0x203, rdata 0x80112233 -> be=1000, load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202 -> 0x00008011.
REQ-029 SH addr 0x12, store_data 0x0000ABCD, ack after 3 wait cycles -> we=1, be=1100, wdata=0xABCDABCD stable 4 req cycles, stall held through BUSY.
REQ-030 LW addr 0x101 or SH addr 0x13 -> fault=1, req=0, stall=0, load_data unchanged.
REQ-031 resetn low mid-BUSY, ack 2 cycles after release -> req drops immediately, FSM IDLE, ack ignored, load_data=0.
REQ-032 Back-to-back LW/SW with ack each cycle -> second access enters BUSY on the edge after DONE; no duplicate request for the first.
